// File: rtl/tff_pkg.sv
// ---------------------------------------------------------------------------
// tff_pkg
// Shared constants for the T flip-flop counter slice.
//   WIDTH_DEFAULT : default counter width in bits (legal range 2..16)
//   dir_e         : count direction, DIR_UP = 1 (increment), DIR_DOWN = 0
// ---------------------------------------------------------------------------
package tff_pkg;

  localparam int WIDTH_DEFAULT = 4;
  localparam int WIDTH_MIN     = 2;
  localparam int WIDTH_MAX     = 16;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage : tff_pkg

// File: rtl/tff_counter_if.sv
// ---------------------------------------------------------------------------
// tff_counter_if
// Control and data bundle of one tff_counter stage.
//   en    : count enable
//   up    : direction (1 = increment, 0 = decrement)
//   load  : synchronous load strobe
//   d     : load value
//   q     : registered count
//   qbar  : bitwise complement of q
//   tc    : terminal count, cascade enable for the next stage
// master drives the controls, slave is the counter itself.
// ---------------------------------------------------------------------------
interface tff_counter_if
  import tff_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             tc;

  modport master (
    output en, up, load, d,
    input  q, qbar, tc
  );

  modport slave (
    input  en, up, load, d,
    output q, qbar, tc
  );

endinterface : tff_counter_if

// File: rtl/tff_cell.sv
// ---------------------------------------------------------------------------
// tff_cell
// One edge-triggered T flip-flop.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset, clears q
//   t    : toggle input, q inverts on the edge when high
//   q    : stored bit
//   qbar : complement of q, combinational
// ---------------------------------------------------------------------------
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic qbar
);

  logic r_q;

  // The stored bit flips when t is high on a rising edge and is cleared
  // immediately whenever reset is pulled low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= 1'b0;
    end else if (t) begin
      r_q <= ~r_q;
    end
  end

  assign q    = r_q;
  assign qbar = ~r_q;

endmodule : tff_cell

// File: rtl/tff_counter.sv
// ---------------------------------------------------------------------------
// tff_counter
// Up/down counter with synchronous load, built purely from T flip-flop
// cells; every state change is produced by driving the cells' toggle
// inputs, there is no adder anywhere in the datapath.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset, forces q to 0
//   bus  : tff_counter_if.slave (en, up, load, d in; q, qbar, tc out)
// Priority on each edge: load, then count enable, then hold.
// ---------------------------------------------------------------------------
module tff_counter
  import tff_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  tff_counter_if.slave  bus
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qbar;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_onesBelow;
  logic [WIDTH-1:0] w_zerosBelow;
  logic             w_dirUp;

  assign w_dirUp = (bus.up == DIR_UP);

  // Ripple prefix chains: bit i is high when every lower bit of q is one
  // (counting up) or zero (counting down). Bit 0 has no lower bits, so it
  // always toggles when counting is enabled.
  assign w_onesBelow[0]  = 1'b1;
  assign w_zerosBelow[0] = 1'b1;

  for (genvar i = 1; i < WIDTH; i++) begin : g_prefix
    assign w_onesBelow[i]  = w_onesBelow[i-1]  &  w_q[i-1];
    assign w_zerosBelow[i] = w_zerosBelow[i-1] & ~w_q[i-1];
  end

  // A load flips exactly those cells whose current bit differs from d,
  // which lands q on d after the edge regardless of en and up.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign w_t[i] = bus.load ? (w_q[i] ^ bus.d[i])
                             : (bus.en & (w_dirUp ? w_onesBelow[i]
                                                  : w_zerosBelow[i]));

    tff_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .t    (w_t[i]),
      .q    (w_q[i]),
      .qbar (w_qbar[i])
    );
  end

  assign bus.q    = w_q;
  assign bus.qbar = w_qbar;

  // Terminal count flags the cycle before a wrap so a cascaded stage can
  // advance on the same edge as this one wraps.
  assign bus.tc = bus.en & (w_dirUp ? (w_q == {WIDTH{1'b1}})
                                    : (w_q == {WIDTH{1'b0}}));

endmodule : tff_counter
